uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmit engine that serialises one byte per request onto the serial line: 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
- Generates its own bit timing from sysclk, with no external baud tick.
- Sits beside the receive-side baud/sampling logic in the CPU's UART peripheral.
- Driven by the peripheral register block through a start/busy/done handshake.

Parameters:
- CLKS_PER_BIT, 10416: sysclk cycles per bit (100 MHz / 9600 baud); legal range 2..65535.
- CNT_W, 16: width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- sysclk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only in the cycle a start is accepted.
- tx_start  input  1  request to send; level-sampled each cycle.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the stop bit completes.
- uart_txd  output  1  serial line; idles high.

Behaviour:
- Reset, asynchronous: state=IDLE, uart_txd=1, tx_busy=0, tx_done=0, counters=0, shift register=0. Reset takes effect immediately, including mid-frame; the partial frame is abandoned with no tx_done.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: uart_txd=1, tx_busy=0. If tx_start=1, latch tx_data into the shift register and go to START.
  - START: uart_txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: uart_txd=shift[0]; after CLKS_PER_BIT cycles shift right and increment bit_idx (3 bits). After bit_idx=7 completes, go to STOP (or PARITY with the option).
  - STOP: uart_txd=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done.
- Timing:
  - Start accepted at edge N: from edge N, tx_busy=1 and uart_txd=0 (start bit begins).
  - Each bit lasts exactly CLKS_PER_BIT cycles. The bit counter counts 0..CLKS_PER_BIT-1, and the bit ends on the cycle it reads CLKS_PER_BIT-1.
  - Full frame: uart_txd is low for the start bit exactly at edges N..N+CLKS_PER_BIT-1.
  - tx_done=1 and tx_busy=0 together at edge N+10*CLKS_PER_BIT (N+11*CLKS_PER_BIT with parity). tx_done returns to 0 the next cycle.
- Boundary cases:
  - tx_start while tx_busy=1 is ignored. The in-flight frame and its latched data are unchanged, and tx_data changes have no effect.
  - tx_start held high in the tx_done cycle (state IDLE) is accepted that cycle. The next start bit begins at the following edge, so back-to-back frames have no idle gap beyond the stop bit.
  - tx_start held high continuously gives continuous back-to-back frames, each latching tx_data at its own acceptance cycle.
  - The bit counter and bit_idx are cleared on every state transition. There is no wrap-around of bit_idx beyond 7.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP. It drives the even-parity bit (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP; frame length is 10*CLKS_PER_BIT.

Test Plan:
All scenarios use CLKS_PER_BIT=4 unless stated otherwise.
- Single byte: reset, then pulse tx_start with tx_data=0xA5 → uart_txd sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; tx_busy high 40 cycles; one tx_done pulse at edge 40 after acceptance.
- Busy rejection: start 0x3C, then pulse tx_start with tx_data=0xFF at cycle 12 → line still carries 0x3C (0,0,0,1,1,1,1,0,0,1); exactly one tx_done.
- Back-to-back: hold tx_start=1 with data 0x01 then 0x80 → second start bit begins at the edge after the first tx_done with no extra idle cycles; line carries both bytes correctly.
- Reset mid-frame: assert reset during data bit 3 of 0x00 → uart_txd=1 and tx_busy=0 immediately (before the next edge); no tx_done; a new frame after release is correct.
- Parity (UART_TX_PARITY_EN defined): send 0x07 → parity bit=1 and frame is 44 cycles; send 0x03 → parity bit=0.
- Long period: CLKS_PER_BIT=10416 with 0x55 → each bit lasts exactly 10416 cycles, measured edge-to-edge on uart_txd.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx - UART transmit engine (8N1, or 8E1 with the parity option).
//
// Serialises one byte per accepted request: start bit (0), eight data bits
// LSB first, optional even-parity bit, stop bit (1). Bit timing is derived
// from sysclk by a free-standing bit-period counter (no external baud tick).
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a PARITY state sits between DATA and STOP and drives the XOR
//                of the eight latched data bits; frame is 11 bit periods.
//   undefined -> DATA goes straight to STOP; frame is 10 bit periods.
//
// Parameters:
//   CLKS_PER_BIT  sysclk cycles per bit (2..65535)
//   CNT_W         bit-period counter width; must hold CLKS_PER_BIT-1
//
// Ports:
//   sysclk    in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   tx_data   in   byte to send, sampled only in the accepting cycle
//   tx_start  in   send request, level-sampled while idle
//   tx_busy   out  high while a frame is in progress
//   tx_done   out  one-cycle pulse when the stop bit completes
//   uart_txd  out  serial line, idles high
//
// All outputs come straight from flops; there is no input-to-output path.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             txd_q,     txd_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at acceptance because the shift register is
    // consumed while the data bits go out.
    logic             parity_q,  parity_d;
`endif

    logic bit_end;
    assign bit_end = (cnt_q == LAST_CNT);

    // Next-state logic. Outputs are computed for the state being entered so
    // that the registered line changes on the very edge the state changes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; that is what keeps this block from inferring latches.
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                txd_d     = 1'b1;
                busy_d    = 1'b0;
                if (tx_start) begin
                    state_d  = S_START;
                    shift_d  = tx_data;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    txd_d   = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
                        txd_d     = parity_q;
`else
                        state_d   = S_STOP;
                        txd_d     = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
                txd_d     = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx - self-checking bench for uart_tx.
//
// The reference model describes a frame as a list of line levels, one per bit
// period, and expects each level for exactly CPB cycles after the accepting
// edge, followed by a one-cycle done pulse. A second instance with the
// full-size bit period checks the long-period timing edge-to-edge.
// Honours UART_TX_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB      = 4;
    localparam int LONG_CPB = 10416;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       sysclk   = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, uart_txd;

    logic [7:0] tx_data_l  = 8'h55;
    logic       tx_start_l = 1'b0;
    logic       tx_busy_l, tx_done_l, uart_txd_l;

    int n_vec = 0;
    int n_err = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .uart_txd (uart_txd)
    );

    uart_tx #(.CLKS_PER_BIT(LONG_CPB)) u_dut_long (
        .sysclk   (sysclk),
        .reset    (reset),
        .tx_data  (tx_data_l),
        .tx_start (tx_start_l),
        .tx_busy  (tx_busy_l),
        .tx_done  (tx_done_l),
        .uart_txd (uart_txd_l)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line level during bit period b of a frame carrying d.
    function automatic logic exp_line(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Send d and check every cycle of the frame plus the done cycle.
    //   reject_at : frame cycle at which a stray 0xFF request is pulsed (-1 none)
    //   hold_start: keep tx_start high through the done cycle with next_d ready
    //   pre_armed : tx_start/tx_data were already set up by the previous frame
    task automatic run_frame(input logic [7:0] d, input int reject_at,
                             input bit hold_start, input logic [7:0] next_d,
                             input bit pre_armed);
        if (!pre_armed) begin
            @(negedge sysclk);
            tx_data  = d;
            tx_start = 1'b1;
        end
        @(posedge sysclk);                    // accepting edge N
        #1;
        tx_data = 8'($urandom);               // must not disturb the frame
        if (!hold_start) tx_start = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge sysclk);
            check("txd",  uart_txd, exp_line(d, k / CPB));
            check("busy", tx_busy,  1);
            check("done", tx_done,  0);
            if (reject_at >= 0) begin
                if (k == reject_at) begin
                    tx_start = 1'b1;
                    tx_data  = 8'hFF;
                end else if (k == reject_at + 1) begin
                    tx_start = 1'b0;
                end
            end
        end
        @(negedge sysclk);                    // edge N + FRAME_CYC
        check("done_pulse", tx_done,  1);
        check("done_busy",  tx_busy,  0);
        check("done_txd",   uart_txd, 1);
        if (hold_start) begin
            tx_data = next_d;
        end else begin
            @(negedge sysclk);
            check("done_clr",  tx_done,  0);
            check("idle_busy", tx_busy,  0);
            check("idle_txd",  uart_txd, 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;
        bit         armed;
        bit         hold;
        int         rej;
        int         cnt;
        logic       prev;

        // Reset state
        #1 reset = 1'b1;
        repeat (3) @(negedge sysclk);
        check("rst_txd",  uart_txd, 1);
        check("rst_busy", tx_busy,  0);
        check("rst_done", tx_done,  0);
        reset = 1'b0;

        // Single byte
        run_frame(8'hA5, -1, 1'b0, 8'h00, 1'b0);

        // Request while busy is ignored
        run_frame(8'h3C, 12, 1'b0, 8'h00, 1'b0);

        // Back-to-back with tx_start held high
        run_frame(8'h01, -1, 1'b1, 8'h80, 1'b0);
        run_frame(8'h80, -1, 1'b0, 8'h00, 1'b1);

        // Random bytes, random chaining and stray requests
        armed = 1'b0;
        cur   = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            nxt  = 8'($urandom);
            hold = (i < 9) && ($urandom_range(0, 1) == 1);
            rej  = (!hold && $urandom_range(0, 2) == 0) ? $urandom_range(0, FRAME_CYC - 2) : -1;
            run_frame(cur, rej, hold, nxt, armed);
            armed = hold;
            cur   = nxt;
        end

        // Reset in the middle of data bit 3 of 0x00
        @(negedge sysclk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(posedge sysclk);
        #1 tx_start = 1'b0;
        for (int k = 0; k <= 4 * CPB + 1; k++) @(negedge sysclk);
        check("mid_txd",  uart_txd, 0);
        check("mid_busy", tx_busy,  1);
        #2 reset = 1'b1;
        #1;                                   // still before the next edge
        check("arst_txd",  uart_txd, 1);
        check("arst_busy", tx_busy,  0);
        check("arst_done", tx_done,  0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        for (int k = 0; k < FRAME_CYC + 2; k++) begin
            @(negedge sysclk);
            check("post_rst_done", tx_done,  0);
            check("post_rst_txd",  uart_txd, 1);
        end
        run_frame(8'($urandom), -1, 1'b0, 8'h00, 1'b0);

`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, -1, 1'b0, 8'h00, 1'b0);
        run_frame(8'h03, -1, 1'b0, 8'h00, 1'b0);
`endif

        // Long period: start bit, d0=1, d1=0 of 0x55, each LONG_CPB cycles
        @(negedge sysclk);
        tx_start_l = 1'b1;
        @(posedge sysclk);
        #1 tx_start_l = 1'b0;
        @(negedge sysclk);
        prev = uart_txd_l;
        check("long_start_lvl", prev, 0);
        for (int b = 0; b < 3; b++) begin
            cnt = 1;
            while (cnt <= LONG_CPB + 50) begin
                @(negedge sysclk);
                if (uart_txd_l != prev) break;
                cnt++;
            end
            check("long_bit_len", cnt, LONG_CPB);
            prev = uart_txd_l;
            check("long_bit_lvl", prev, exp_line(8'h55, b + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
